// File: rtl/u_lsu_pkg.sv
// rtl/u_lsu_pkg.sv - funct3 codes, FSM state type and access legality check for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;

  // Access size is f3[1:0] for every legal encoding, so alignment is checked on that alone.
  function automatic logic lsu_legal(input logic ld, input logic st,
                                     input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    if (ld && st)
      ok = 1'b0;
    else if (ld)
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    else
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    case (f3[1:0])
      2'b01:   ok = ok && !off[0];
      2'b10:   ok = ok && (off == 2'b00);
      default: ok = ok;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/u_lsu_ldalign.sv
// rtl/u_lsu_ldalign.sv - selects the addressed byte/half of a read word and extends it
module u_lsu_ldalign
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = rdata[{offset[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/u_lsu.sv
// rtl/u_lsu.sv - load/store unit: legality check, byte-lane store alignment, load writeback
module u_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              lsu_req_v,
  output logic              lsu_req_rdy,
  input  logic              lsu_ld,
  input  logic              lsu_st,
  input  logic [2:0]        lsu_f3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [4:0]        lsu_rd_a,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [XLEN-1:0]   dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic              lsu_rd_e,
  output logic [4:0]        lsu_rd_a_o,
  output logic [XLEN-1:0]   lsu_rd_d,
  output logic              lsu_err,
  output logic              lsu_busy
);

  lsu_state_t        state, state_nx;
  logic              ld_q, ld_nx;
  logic [2:0]        f3_q, f3_nx;
  logic [1:0]        off_q, off_nx;
  logic [4:0]        rd_a_q, rd_a_nx;
  logic              dm_req_nx, dm_we_nx;
  logic [3:0]        dm_be_nx;
  logic [ADDR_W-1:0] dm_addr_nx;
  logic [XLEN-1:0]   dm_wdata_nx;
  logic              rd_e_nx, err_nx;
  logic [4:0]        rd_a_o_nx;
  logic [XLEN-1:0]   rd_d_nx, ld_data;

  assign lsu_req_rdy = (state == IDLE);
  assign lsu_busy    = (state != IDLE);

  u_lsu_ldalign u_ldalign (
    .f3     (f3_q),
    .offset (off_q),
    .rdata  (dm_rdata),
    .data   (ld_data)
  );

  always_comb begin
    state_nx    = state;
    ld_nx       = ld_q;
    f3_nx       = f3_q;
    off_nx      = off_q;
    rd_a_nx     = rd_a_q;
    dm_req_nx   = dm_req;
    dm_we_nx    = dm_we;
    dm_be_nx    = dm_be;
    dm_addr_nx  = dm_addr;
    dm_wdata_nx = dm_wdata;
    rd_e_nx     = 1'b0;
    rd_a_o_nx   = lsu_rd_a_o;
    rd_d_nx     = lsu_rd_d;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_req_v && (lsu_ld || lsu_st)) begin
          ld_nx   = lsu_ld;
          f3_nx   = lsu_f3;
          off_nx  = lsu_addr[1:0];
          rd_a_nx = lsu_rd_a;
          if (!lsu_legal(lsu_ld, lsu_st, lsu_f3, lsu_addr[1:0])) begin
            err_nx = 1'b1;
          end else begin
            state_nx   = REQ;
            dm_req_nx  = 1'b1;
            dm_we_nx   = lsu_st;
            dm_addr_nx = {lsu_addr[ADDR_W-1:2], 2'b00};
            if (lsu_ld) begin
              dm_be_nx    = 4'b1111;
              dm_wdata_nx = '0;
            end else begin
              // Replicate narrow store data so every enabled lane carries it.
              case (lsu_f3[1:0])
                2'b00: begin
                  dm_be_nx    = 4'b0001 << lsu_addr[1:0];
                  dm_wdata_nx = {4{lsu_wdata[7:0]}};
                end
                2'b01: begin
                  dm_be_nx    = 4'b0011 << {lsu_addr[1], 1'b0};
                  dm_wdata_nx = {2{lsu_wdata[15:0]}};
                end
                default: begin
                  dm_be_nx    = 4'b1111;
                  dm_wdata_nx = lsu_wdata;
                end
              endcase
            end
          end
        end
      end
      REQ: begin
        if (dm_gnt) begin
          dm_req_nx = 1'b0;
          state_nx  = ld_q ? WAIT : IDLE;
        end
      end
      WAIT: begin
        if (dm_rvalid) begin
          rd_e_nx   = (rd_a_q != 5'd0);
          rd_a_o_nx = rd_a_q;
          rd_d_nx   = ld_data;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ld_q       <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      rd_a_q     <= 5'd0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_be      <= 4'b0000;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      lsu_rd_e   <= 1'b0;
      lsu_rd_a_o <= 5'd0;
      lsu_rd_d   <= '0;
      lsu_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      ld_q       <= ld_nx;
      f3_q       <= f3_nx;
      off_q      <= off_nx;
      rd_a_q     <= rd_a_nx;
      dm_req     <= dm_req_nx;
      dm_we      <= dm_we_nx;
      dm_be      <= dm_be_nx;
      dm_addr    <= dm_addr_nx;
      dm_wdata   <= dm_wdata_nx;
      lsu_rd_e   <= rd_e_nx;
      lsu_rd_a_o <= rd_a_o_nx;
      lsu_rd_d   <= rd_d_nx;
      lsu_err    <= err_nx;
    end
  end

endmodule

// File: tb/tb_u_lsu.sv
// tb/tb_u_lsu.sv - scoreboard bench for u_lsu with a byte-level memory reference model
module tb_u_lsu;
  import lsu_pkg::*;

  logic        clk, rstn;
  logic        lsu_req_v, lsu_req_rdy, lsu_ld, lsu_st;
  logic [2:0]  lsu_f3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [4:0]  lsu_rd_a;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        lsu_rd_e, lsu_err, lsu_busy;
  logic [4:0]  lsu_rd_a_o;
  logic [31:0] lsu_rd_d;

  u_lsu #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .lsu_req_v(lsu_req_v), .lsu_req_rdy(lsu_req_rdy),
    .lsu_ld(lsu_ld), .lsu_st(lsu_st), .lsu_f3(lsu_f3), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_rd_a(lsu_rd_a), .dm_req(dm_req), .dm_we(dm_we),
    .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .lsu_rd_e(lsu_rd_e),
    .lsu_rd_a_o(lsu_rd_a_o), .lsu_rd_d(lsu_rd_d), .lsu_err(lsu_err), .lsu_busy(lsu_busy)
  );

  typedef struct packed {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} mem_t;
  typedef struct packed {logic [4:0] rd; logic [31:0] d; logic [31:0] cyc;} wb_t;

  mem_t exp_mem[$];
  wb_t  exp_wb[$];
  int   exp_err[$];

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int gnt_dly = 0, rv_dly = 0, spur_req = 0;
  logic [7:0] bmem [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] i);
    return (i * 32'h0100_0193) ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [7:0] rd_byte(input int a);
    logic [31:0] w;
    if (bmem.exists(a)) return bmem[a];
    w = init_word(a / 4);
    return w[8*(a%4) +: 8];
  endfunction

  // Bus-side memory: grants and returns read data after programmable delays.
  initial begin : responder
    logic [31:0] wmem [0:255];
    int gcnt, rcnt, spur_done, ridx;
    bit pend, prev_req, prev_gnt;
    logic [31:0] h_addr, h_wdata;
    logic [4:0] h_webe;
    mem_t m;
    for (int i = 0; i < 256; i++) wmem[i] = init_word(i);
    gcnt = 0; rcnt = 0; spur_done = 0; ridx = 0; pend = 0; prev_req = 0; prev_gnt = 0;
    h_addr = 0; h_wdata = 0; h_webe = 0;
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
    forever begin
      @(negedge clk);
      dm_gnt = 0; dm_rvalid = 0;
      if (spur_done != spur_req) begin
        dm_rvalid = 1; dm_rdata = 32'hFFFF_FFFF; spur_done = spur_req;
      end
      if (pend) begin
        if (rcnt >= rv_dly) begin
          dm_rvalid = 1; dm_rdata = wmem[ridx]; pend = 0;
        end else rcnt++;
      end
      if (prev_gnt) chk("req_drop_after_gnt", {31'd0, dm_req}, 0);
      if (dm_req) begin
        if (prev_req && !prev_gnt) begin
          chk("stable_addr", dm_addr, h_addr);
          chk("stable_wdata", dm_wdata, h_wdata);
          chk("stable_we_be", {27'd0, dm_we, dm_be}, {27'd0, h_webe});
        end else begin
          h_addr = dm_addr; h_wdata = dm_wdata; h_webe = {dm_we, dm_be};
        end
        if (gcnt >= gnt_dly) begin
          dm_gnt = 1; gcnt = 0;
          if (exp_mem.size() == 0) chk("unexpected_dm_access", 1, 0);
          else begin
            m = exp_mem.pop_front();
            chk("dm_we", {31'd0, dm_we}, {31'd0, m.we});
            chk("dm_be", {28'd0, dm_be}, {28'd0, m.be});
            chk("dm_addr", dm_addr, m.addr);
            chk("dm_wdata", dm_wdata, m.wdata);
          end
          if (dm_we) begin
            for (int k = 0; k < 4; k++)
              if (dm_be[k]) wmem[dm_addr[9:2]][8*k +: 8] = dm_wdata[8*k +: 8];
          end else begin
            pend = 1; rcnt = 0; ridx = int'(dm_addr[9:2]);
          end
        end else gcnt++;
      end else gcnt = 0;
      prev_req = dm_req; prev_gnt = dm_gnt;
    end
  end

  initial begin : monitor
    wb_t w;
    int e;
    forever begin
      @(negedge clk);
      if (lsu_rd_e) begin
        if (exp_wb.size() == 0) chk("unexpected_writeback", 1, 0);
        else begin
          w = exp_wb.pop_front();
          chk("wb_rd_a", {27'd0, lsu_rd_a_o}, {27'd0, w.rd});
          chk("wb_data", lsu_rd_d, w.d);
          chk("wb_cycle", cyc, w.cyc);
        end
      end
      if (lsu_err) begin
        if (exp_err.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = exp_err.pop_front();
          chk("err_cycle", cyc, e);
        end
      end
    end
  end

  // ab: 0 normal, 1 reset while in REQ, 2 reset while in WAIT
  task automatic issue(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int gd, input int rvd,
                       input int ab);
    int t, n, sz, o;
    bit ok;
    logic [31:0] v, lim;
    mem_t m;
    wb_t w;
    t = 0;
    while (!lsu_req_rdy && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("rdy_timeout", 0, 1);
    gnt_dly = gd; rv_dly = rvd;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    o = int'(addr % 4);
    ok = ld ^ st;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ok = 0;
    if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) ok = 0;
    if (addr % sz != 0) ok = 0;
    n = cyc;
    if ((ld || st) && !ok) exp_err.push_back(n + 1);
    else if (ok) begin
      m.addr = addr & ~32'h3; m.we = st; m.be = 4'h0; m.wdata = 0;
      lim = (32'h1 << (8*sz)) - 1;
      if (st) begin
        for (int k = 0; k < sz; k++) m.be[o+k] = 1'b1;
        for (int k = 0; k < 4/sz; k++) m.wdata |= (wd & lim) << (8*sz*k);
        if (ab != 1)
          for (int k = 0; k < sz; k++) bmem[int'(addr) + k] = wd[8*k +: 8];
      end else begin
        m.be = 4'hF; v = 0;
        for (int k = 0; k < sz; k++) v |= 32'(rd_byte(int'(addr) + k)) << (8*k);
        if (!f3[2] && sz < 4 && v[8*sz-1]) v |= ~lim;
        if (rd != 0 && ab == 0) begin
          w.rd = rd; w.d = v; w.cyc = n + 3 + gd + rvd; exp_wb.push_back(w);
        end
      end
      if (ab != 1) exp_mem.push_back(m);
    end
    lsu_req_v = 1; lsu_ld = ld; lsu_st = st; lsu_f3 = f3; lsu_addr = addr; lsu_wdata = wd; lsu_rd_a = rd;
    @(negedge clk);
    lsu_req_v = 0; lsu_ld = 0; lsu_st = 0;
    if (ab != 0) begin
      if (ab == 2) @(negedge clk);
      rstn = 0;
      #1;
      chk("rst_dm_req", {31'd0, dm_req}, 0);
      chk("rst_rdy", {31'd0, lsu_req_rdy}, 1);
      chk("rst_busy", {31'd0, lsu_busy}, 0);
      @(negedge clk);
      rstn = 1;
      repeat (8) @(negedge clk);
      chk("post_rst_rdy", {31'd0, lsu_req_rdy}, 1);
    end else if (ok) begin
      t = 0;
      while (!lsu_req_rdy && t < 100) begin
        chk("busy_while_active", {31'd0, lsu_busy}, 1);
        @(negedge clk); t++;
      end
      if (t >= 100) chk("done_timeout", 0, 1);
      if (st) chk("st_rdy_latency", cyc, n + 2 + gd);
      chk("idle_busy", {31'd0, lsu_busy}, 0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    logic [2:0] f3;
    logic [31:0] a;
    int r;
    rstn = 0; lsu_req_v = 0; lsu_ld = 0; lsu_st = 0; lsu_f3 = 0;
    lsu_addr = 0; lsu_wdata = 0; lsu_rd_a = 0;
    repeat (2) @(negedge clk);
    chk("reset_rdy", {31'd0, lsu_req_rdy}, 1);
    chk("reset_busy", {31'd0, lsu_busy}, 0);
    chk("reset_dm_req", {31'd0, dm_req}, 0);
    chk("reset_dm_be", {28'd0, dm_be}, 0);
    chk("reset_dm_addr", dm_addr, 0);
    chk("reset_rd_e", {31'd0, lsu_rd_e}, 0);
    chk("reset_rd_d", lsu_rd_d, 0);
    chk("reset_err", {31'd0, lsu_err}, 0);
    rstn = 1;
    @(negedge clk);

    issue(0, 1, F3_W, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 0);
    issue(0, 1, F3_B, 32'h103, 32'h000000A5, 5'd0, 0, 0, 0);
    issue(0, 1, F3_W, 32'h200, 32'h80FF7F01, 5'd0, 0, 0, 0);
    issue(1, 0, F3_B, 32'h203, 32'h0, 5'd5, 0, 0, 0);
    issue(1, 0, F3_BU, 32'h203, 32'h0, 5'd6, 0, 0, 0);
    issue(1, 0, F3_H, 32'h202, 32'h0, 5'd7, 0, 0, 0);
    issue(1, 0, F3_HU, 32'h200, 32'h0, 5'd5, 0, 0, 0);
    issue(1, 0, F3_W, 32'h102, 32'h0, 5'd3, 0, 0, 0);
    issue(1, 0, F3_H, 32'h101, 32'h0, 5'd3, 0, 0, 0);
    issue(1, 0, 3'b011, 32'h100, 32'h0, 5'd3, 0, 0, 0);
    issue(1, 1, F3_W, 32'h100, 32'h0, 5'd3, 0, 0, 0);
    issue(0, 1, 3'b100, 32'h100, 32'h0, 5'd0, 0, 0, 0);
    issue(1, 0, F3_W, 32'h100, 32'h0, 5'd9, 3, 2, 0);
    spur_req++;
    repeat (3) @(negedge clk);
    issue(1, 0, F3_W, 32'h200, 32'h0, 5'd0, 0, 0, 0);
    issue(1, 0, F3_W, 32'h200, 32'h0, 5'd12, 0, 5, 2);
    issue(0, 1, F3_W, 32'h300, 32'h12345678, 5'd0, 6, 0, 1);
    lsu_req_v = 1;
    @(negedge clk);
    lsu_req_v = 0;
    @(negedge clk);
    chk("ignored_req_rdy", {31'd0, lsu_req_rdy}, 1);

    for (int i = 0; i < 80; i++) begin
      r = $urandom % 10;
      f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 1023));
      if ($urandom % 4 != 0) a = a & ~((32'h1 << f3[1:0]) - 1);
      if (r == 0) begin
        lsu_req_v = 1; @(negedge clk); lsu_req_v = 0; @(negedge clk);
      end else
        issue(r == 1 || r > 5, r == 1 || (r > 1 && r <= 5), f3, a, $urandom,
              5'($urandom % 32), $urandom % 3, $urandom % 3, 0);
    end

    repeat (6) @(negedge clk);
    chk("leftover_mem", exp_mem.size(), 0);
    chk("leftover_wb", exp_wb.size(), 0);
    chk("leftover_err", exp_err.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
